// File: rtl/ir_fetch_ctrl_pkg.sv
// Shared encodings for the instruction-register fetch sequencer.
// State, IR control and wait-counter definitions used by ir_fetch_ctrl and its counter.
package ir_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        REQ_HI = 3'd2,
        VALID  = 3'd3,
        ERR    = 3'd4
    } fetch_state_e;

    localparam logic [1:0] FS_CLEAR = 2'b00;
    localparam logic [1:0] FS_LOAD  = 2'b01;

    localparam logic L_H_LOW  = 1'b0;
    localparam logic L_H_HIGH = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/ir_fetch_ctrl_timeout_ctr.sv
// Bus wait counter for one outstanding byte request.
// tc is raised during the last cycle a request may wait before the bus error is taken.
module fetch_timeout_ctr
    import ir_fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CNT_W'(1);
    end

    // Terminal when this unacked wait brings the count up to TIMEOUT.
    assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ir_fetch_ctrl.sv
// Two-byte instruction fetch sequencer: requests PC and PC+1, steers each byte
// into the IR half, then hands the instruction to decode with valid/ack.
module ir_fetch_ctrl
    import ir_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ack,
    output logic [1:0]        ir_funsel,
    output logic              ir_e,
    output logic              ir_l_h,
    output logic              instr_valid,
    input  logic              instr_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              bus_err,
    input  logic              err_clr
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              cnt_clr, cnt_inc, cnt_tc;
    logic [CNT_W-1:0]  cnt;

    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    assign mem_addr = pc;
    // The flag is sticky for exactly as long as the FSM sits in ERR.
    assign bus_err  = (state == ERR);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        mem_rd_req  = 1'b0;
        ir_e        = 1'b0;
        ir_funsel   = FS_CLEAR;
        ir_l_h      = L_H_LOW;
        instr_valid = 1'b0;

        // Redirect wins over any ack seen in the same cycle and clears the IR.
        if (pc_load && state != ERR) begin
            pc_nxt    = pc_in;
            cnt_clr   = 1'b1;
            ir_e      = 1'b1;
            ir_funsel = FS_CLEAR;
            state_nxt = (state == IDLE) ? IDLE : REQ_LO;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (start)
                        state_nxt = REQ_LO;
                end
                REQ_LO, REQ_HI: begin
                    mem_rd_req = 1'b1;
                    ir_l_h     = (state == REQ_HI) ? L_H_HIGH : L_H_LOW;
                    if (mem_rd_ack) begin
                        ir_e      = 1'b1;
                        ir_funsel = FS_LOAD;
                        pc_nxt    = pc + PC_ONE;
                        cnt_clr   = 1'b1;
                        state_nxt = (state == REQ_HI) ? VALID : REQ_HI;
                    end else begin
                        cnt_inc = 1'b1;
                        if (cnt_tc)
                            state_nxt = ERR;
                    end
                end
                VALID: begin
                    instr_valid = 1'b1;
                    cnt_clr     = 1'b1;
                    if (instr_ack)
                        state_nxt = halt ? IDLE : REQ_LO;
                end
                ERR: begin
                    cnt_clr = 1'b1;
                    if (err_clr)
                        state_nxt = IDLE;
                end
                default: begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Directed bench for ir_fetch_ctrl: a cycle table for the main flow plus
// hand-written wait-state, VALID-hold and timeout sequences.
module tb_ir_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, halt = 1'b0, pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_rd_ack = 1'b0;
    logic [1:0]  ir_funsel;
    logic        ir_e, ir_l_h, instr_valid;
    logic        instr_ack = 1'b0;
    logic [15:0] pc;
    logic        bus_err;
    logic        err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ir_fetch_ctrl #(.ADDR_W(16), .RESET_PC(16'h0100), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_load(pc_load),
        .pc_in(pc_in), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_ack(mem_rd_ack), .ir_funsel(ir_funsel), .ir_e(ir_e),
        .ir_l_h(ir_l_h), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .pc(pc), .bus_err(bus_err), .err_clr(err_clr)
    );

    typedef struct {
        logic        st, hl, ld;
        logic [15:0] pin;
        logic        ak, ia, ec;
        logic [38:0] exp;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [38:0] ex(input logic req, input logic e, input logic [1:0] fs,
                                       input logic lh, input logic vld, input logic err,
                                       input logic [15:0] p);
        return {req, p, e, fs, lh, vld, err, p};
    endfunction

    function automatic vec_t mk(input logic st, input logic hl, input logic ld,
                                input logic [15:0] pin, input logic ak, input logic ia,
                                input logic [38:0] e);
        vec_t v;
        v.st = st; v.hl = hl; v.ld = ld; v.pin = pin;
        v.ak = ak; v.ia = ia; v.ec = 1'b0; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic hl, input logic ld, input logic [15:0] pin,
                         input logic ak, input logic ia, input logic ec);
        start = st; halt = hl; pc_load = ld; pc_in = pin;
        mem_rd_ack = ak; instr_ack = ia; err_clr = ec;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] obs();
        return {mem_rd_req, mem_addr, ir_e, ir_funsel, ir_l_h, instr_valid, bus_err, pc};
    endfunction

    initial begin
        int e_cnt;
        //               st hl ld pin      ak ia   req e  fs     lh vld err pc
        tbl[0]  = mk(0, 0, 0, 16'h0000, 0, 0, ex(0, 0, 2'b00, 0, 0, 0, 16'h0100));
        tbl[1]  = mk(1, 0, 0, 16'h0000, 0, 0, ex(0, 0, 2'b00, 0, 0, 0, 16'h0100));
        tbl[2]  = mk(0, 0, 0, 16'h0000, 1, 0, ex(1, 1, 2'b01, 0, 0, 0, 16'h0100));
        tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 0, ex(1, 1, 2'b01, 1, 0, 0, 16'h0101));
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 0, ex(0, 0, 2'b00, 0, 1, 0, 16'h0102));
        tbl[5]  = mk(0, 0, 0, 16'h0000, 0, 1, ex(0, 0, 2'b00, 0, 1, 0, 16'h0102));
        tbl[6]  = mk(0, 0, 0, 16'h0000, 0, 0, ex(1, 0, 2'b00, 0, 0, 0, 16'h0102));
        tbl[7]  = mk(0, 0, 0, 16'h0000, 1, 0, ex(1, 1, 2'b01, 0, 0, 0, 16'h0102));
        tbl[8]  = mk(0, 0, 1, 16'h2000, 1, 0, ex(0, 1, 2'b00, 0, 0, 0, 16'h0103));
        tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 0, ex(1, 0, 2'b00, 0, 0, 0, 16'h2000));
        tbl[10] = mk(0, 0, 1, 16'hFFFF, 1, 0, ex(0, 1, 2'b00, 0, 0, 0, 16'h2000));
        tbl[11] = mk(0, 0, 0, 16'h0000, 1, 0, ex(1, 1, 2'b01, 0, 0, 0, 16'hFFFF));
        tbl[12] = mk(0, 0, 0, 16'h0000, 1, 0, ex(1, 1, 2'b01, 1, 0, 0, 16'h0000));
        tbl[13] = mk(0, 1, 0, 16'h0000, 0, 1, ex(0, 0, 2'b00, 0, 1, 0, 16'h0001));
        tbl[14] = mk(0, 0, 0, 16'h0000, 0, 0, ex(0, 0, 2'b00, 0, 0, 0, 16'h0001));
        tbl[15] = mk(0, 0, 1, 16'h0100, 0, 0, ex(0, 1, 2'b00, 0, 0, 0, 16'h0001));
        tbl[16] = mk(0, 0, 0, 16'h0000, 0, 0, ex(0, 0, 2'b00, 0, 0, 0, 16'h0100));

        @(negedge clk);
        chk("reset", 64'(obs()), 64'(ex(0, 0, 2'b00, 0, 0, 0, 16'h0100)));
        adv();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].st, tbl[i].hl, tbl[i].ld, tbl[i].pin, tbl[i].ak, tbl[i].ia, tbl[i].ec);
            chk($sformatf("vec%0d", i), 64'(obs()), 64'(tbl[i].exp));
            adv();
        end

        // Three wait cycles per byte, request and address held stable.
        drive(1, 0, 0, 16'h0, 0, 0, 0);
        chk("ws_idle_req", 64'(mem_rd_req), 64'(0));
        adv();
        e_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            logic ak;
            ak = (k == 3 || k == 7);
            drive(0, 0, 0, 16'h0, ak, 0, 0);
            chk($sformatf("ws_req%0d", k), 64'({mem_rd_req, mem_addr}),
                64'({1'b1, (k < 4) ? 16'h0100 : 16'h0101}));
            chk($sformatf("ws_e%0d", k), 64'(ir_e), 64'(ak));
            if (ir_e) e_cnt++;
            adv();
        end
        chk("ws_e_pulses", 64'(e_cnt), 64'(2));

        for (int h = 0; h < 5; h++) begin
            drive(0, 0, 0, 16'h0, 0, 0, 0);
            chk($sformatf("hold%0d", h), 64'({instr_valid, mem_rd_req, pc}), 64'({2'b10, 16'h0102}));
            adv();
        end
        drive(0, 1, 0, 16'h0, 0, 1, 0);
        chk("halt_ack", 64'(instr_valid), 64'(1));
        adv();
        for (int h = 0; h < 2; h++) begin
            drive(0, 0, 0, 16'h0, 0, 0, 0);
            chk($sformatf("halt_idle%0d", h), 64'({instr_valid, mem_rd_req, ir_e}), 64'(0));
            adv();
        end

        // Timeout after four unacked wait cycles.
        drive(1, 0, 0, 16'h0, 0, 0, 0);
        adv();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 16'h0, 0, 0, 0);
            chk($sformatf("tmo_wait%0d", k), 64'({mem_rd_req, bus_err}), 64'(2'b10));
            adv();
        end
        drive(1, 0, 1, 16'h5555, 0, 0, 0);
        chk("tmo_err", 64'({bus_err, mem_rd_req, ir_e, pc}), 64'({3'b100, 16'h0102}));
        adv();
        drive(0, 0, 0, 16'h0, 0, 0, 1);
        chk("err_held", 64'({bus_err, pc}), 64'({1'b1, 16'h0102}));
        adv();
        drive(0, 0, 0, 16'h0, 0, 0, 0);
        chk("err_cleared", 64'({bus_err, mem_rd_req, pc}), 64'({2'b00, 16'h0102}));
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
